// File: rtl/vma_ref_pkg.sv
// Shared types for the VMA reference scheduler: FSM states, datapath select
// encodings, requester indices and the fixed-priority winner pick.
package vma_ref_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_MEM,
        ST_FAIL,
        ST_NXM,
        ST_BRK,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_AD       = 2'b00,
        SRC_PC_MAGIC = 2'b01,
        SRC_PC_INC   = 2'b10,
        SRC_HOLD     = 2'b11
    } vma_src_t;

    typedef enum logic [1:0] {
        VMAX_VMA      = 2'b00,
        VMAX_PC       = 2'b01,
        VMAX_PREV_SEC = 2'b10,
        VMAX_AD       = 2'b11
    } vmax_sel_t;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_PF = 2'd2;
    localparam req_id_t REQ_PI = 2'd1;
    localparam req_id_t REQ_UC = 2'd0;

    typedef struct packed {
        logic [2:0] grant;
        vma_src_t   vma_src;
        vmax_sel_t  vmax_sel;
        logic       load_vma;
        logic       load_vma_held;
        logic       mem_req;
        logic       mem_write;
        logic [2:0] done;
        logic       pf_trap;
        logic       nxm_trap;
        logic       brk_trap;
    } sched_out_t;

    // Page refill outranks PI, which outranks microcode.
    function automatic req_id_t pick_winner(input logic [2:0] req);
        if (req[REQ_PF]) return REQ_PF;
        if (req[REQ_PI]) return REQ_PI;
        return REQ_UC;
    endfunction

    function automatic logic [2:0] id_onehot(input req_id_t id);
        return 3'b001 << id;
    endfunction

endpackage

// File: rtl/vma_ref_sched_if.sv
// Request, datapath-control and MBOX handshake bundle for the VMA scheduler.
interface vma_ref_sched_if;
    logic [2:0] req;
    logic [5:0] req_src;
    logic [5:0] req_vmax;
    logic [2:0] req_write;
    logic       ac_ref;
    logic       match_13_35;
    logic       brk_en_rd;
    logic       brk_en_wr;
    logic       mem_ack;
    logic       page_fail;

    logic [2:0] grant;
    logic [1:0] vma_src;
    logic [1:0] vmax_sel;
    logic       load_vma;
    logic       load_vma_held;
    logic       mem_req;
    logic       mem_write;
    logic [2:0] done;
    logic       pf_trap;
    logic       nxm_trap;
    logic       brk_trap;

    modport slave (
        input  req, req_src, req_vmax, req_write, ac_ref, match_13_35,
               brk_en_rd, brk_en_wr, mem_ack, page_fail,
        output grant, vma_src, vmax_sel, load_vma, load_vma_held, mem_req,
               mem_write, done, pf_trap, nxm_trap, brk_trap
    );

    modport master (
        output req, req_src, req_vmax, req_write, ac_ref, match_13_35,
               brk_en_rd, brk_en_wr, mem_ack, page_fail,
        input  grant, vma_src, vmax_sel, load_vma, load_vma_held, mem_req,
               mem_write, done, pf_trap, nxm_trap, brk_trap
    );
endinterface

// File: rtl/vma_ref_timer.sv
// MBOX wait counter: cleared outside MEM, counts MEM cycles, flags the last
// cycle before an NXM timeout.
module vma_ref_timer #(
    parameter int NXM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(NXM_TIMEOUT + 1);

    logic [CW-1:0] count_d, count_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding its old value (no latch).
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CW'(NXM_TIMEOUT - 1));

endmodule

// File: rtl/vma_ref_sched.sv
// Arbitrates VMA-using references, drives VMA load/select, classifies the new
// VMA (AC / break / memory) and runs the MBOX handshake with NXM timeout.
module vma_ref_sched
    import vma_ref_pkg::*;
#(
    parameter int NXM_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    vma_ref_sched_if.slave  bus
);
    state_t     state_d, state_q;
    req_id_t    id_d, id_q;
    vma_src_t   src_d, src_q;
    vmax_sel_t  vmax_d, vmax_q;
    logic       write_d, write_q;
    sched_out_t out_d, out_q;

    req_id_t    winner;
    logic       tmr_expire;
    logic       brk_armed;

    assign winner    = pick_winner(bus.req);
    assign brk_armed = write_q ? bus.brk_en_wr : bus.brk_en_rd;

    vma_ref_timer #(.NXM_TIMEOUT(NXM_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != ST_MEM),
        .enable (state_q == ST_MEM),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        src_d   = src_q;
        vmax_d  = vmax_q;
        write_d = write_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    id_d    = winner;
                    src_d   = vma_src_t'(bus.req_src[{winner, 1'b0} +: 2]);
                    vmax_d  = vmax_sel_t'(bus.req_vmax[{winner, 1'b0} +: 2]);
                    write_d = bus.req_write[winner];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (bus.match_13_35 && brk_armed) state_d = ST_BRK;
                else if (bus.ac_ref)              state_d = ST_DONE;
                else                              state_d = ST_MEM;
            end
            ST_MEM: begin
                if (bus.page_fail)    state_d = ST_FAIL;
                else if (bus.mem_ack) state_d = ST_DONE;
                else if (tmr_expire)  state_d = ST_NXM;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop aligned with it.
    always_comb begin
        out_d = '0;
        if (state_d != ST_IDLE) out_d.grant = id_onehot(id_d);
        unique case (state_d)
            ST_LOAD: begin
                out_d.load_vma = 1'b1;
                out_d.vma_src  = src_d;
                out_d.vmax_sel = vmax_d;
            end
            ST_MEM: begin
                out_d.mem_req   = 1'b1;
                out_d.mem_write = write_d;
            end
            ST_FAIL: {out_d.load_vma_held, out_d.pf_trap}  = 2'b11;
            ST_NXM:  {out_d.load_vma_held, out_d.nxm_trap} = 2'b11;
            ST_BRK:  {out_d.load_vma_held, out_d.brk_trap} = 2'b11;
            ST_DONE: out_d.done = id_onehot(id_d);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= REQ_UC;
            src_q   <= SRC_AD;
            vmax_q  <= VMAX_VMA;
            write_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            src_q   <= src_d;
            vmax_q  <= vmax_d;
            write_q <= write_d;
            out_q   <= out_d;
        end
    end

    assign bus.grant         = out_q.grant;
    assign bus.vma_src       = out_q.vma_src;
    assign bus.vmax_sel      = out_q.vmax_sel;
    assign bus.load_vma      = out_q.load_vma;
    assign bus.load_vma_held = out_q.load_vma_held;
    assign bus.mem_req       = out_q.mem_req;
    assign bus.mem_write     = out_q.mem_write;
    assign bus.done          = out_q.done;
    assign bus.pf_trap       = out_q.pf_trap;
    assign bus.nxm_trap      = out_q.nxm_trap;
    assign bus.brk_trap      = out_q.brk_trap;

endmodule

// File: tb/tb_vma_ref_sched.sv
// Directed bench for vma_ref_sched: per-cycle expected output vectors are queued
// with each scenario and popped/compared one clock after every edge.
module tb_vma_ref_sched;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vma_ref_sched_if bus ();

    vma_ref_sched #(.NXM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {grant, vma_src, vmax_sel, load_vma, load_vma_held, mem_req, mem_write, done, pf, nxm, brk}
    logic [16:0] obs;
    assign obs = {bus.grant, bus.vma_src, bus.vmax_sel, bus.load_vma, bus.load_vma_held,
                  bus.mem_req, bus.mem_write, bus.done, bus.pf_trap, bus.nxm_trap, bus.brk_trap};

    typedef struct {
        string       tag;
        logic [16:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [16:0] e_idle();
        return 17'b0;
    endfunction
    function automatic logic [16:0] e_load(logic [2:0] g, logic [1:0] s, logic [1:0] x);
        return {g, s, x, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000};
    endfunction
    function automatic logic [16:0] e_grant(logic [2:0] g);
        return {g, 14'b0};
    endfunction
    function automatic logic [16:0] e_mem(logic [2:0] g, logic w);
        return {g, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, w, 3'b000, 3'b000};
    endfunction
    function automatic logic [16:0] e_done(logic [2:0] g);
        return {g, 2'b00, 2'b00, 4'b0000, g, 3'b000};
    endfunction
    // t = {pf, nxm, brk}
    function automatic logic [16:0] e_trap(logic [2:0] g, logic [2:0] t);
        return {g, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, t};
    endfunction

    task automatic check(input string tag, input logic [16:0] o, input logic [16:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input logic [16:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_underflow observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.req         = '0;
        bus.req_src     = '0;
        bus.req_vmax    = '0;
        bus.req_write   = '0;
        bus.ac_ref      = 1'b0;
        bus.match_13_35 = 1'b0;
        bus.brk_en_rd   = 1'b0;
        bus.brk_en_wr   = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.page_fail   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        push("reset", e_idle());
        pop_cmp();
        rst_n = 1'b1;
        push("idle_after_reset", e_idle());
        cyc();

        // Microcode read, ack in third MEM cycle.
        bus.req      = 3'b001;
        bus.req_src  = 6'b00_00_10;
        bus.req_vmax = 6'b00_00_01;
        push("uc_load",  e_load(3'b001, 2'b10, 2'b01));
        push("uc_check", e_grant(3'b001));
        push("uc_mem0",  e_mem(3'b001, 1'b0));
        push("uc_mem1",  e_mem(3'b001, 1'b0));
        push("uc_mem2",  e_mem(3'b001, 1'b0));
        push("uc_done",  e_done(3'b001));
        push("uc_idle",  e_idle());
        repeat (5) cyc();
        bus.mem_ack = 1'b1;
        bus.req     = 3'b000;
        cyc();
        bus.mem_ack = 1'b0;
        cyc();

        // All three request at once; AC refs keep each reference short.
        bus.req      = 3'b111;
        bus.req_src  = 6'b11_01_10;
        bus.req_vmax = 6'b10_11_01;
        bus.ac_ref   = 1'b1;
        push("pf_load",  e_load(3'b100, 2'b11, 2'b10));
        push("pf_check", e_grant(3'b100));
        push("pf_done",  e_done(3'b100));
        push("pf_idle",  e_idle());
        push("pi_load",  e_load(3'b010, 2'b01, 2'b11));
        push("pi_check", e_grant(3'b010));
        push("pi_done",  e_done(3'b010));
        push("pi_idle",  e_idle());
        push("uc_load2", e_load(3'b001, 2'b10, 2'b01));
        push("uc_check2", e_grant(3'b001));
        push("uc_ac_done", e_done(3'b001));
        push("uc_idle2", e_idle());
        repeat (3) cyc();
        bus.req = 3'b011;
        repeat (4) cyc();
        bus.req = 3'b001;
        repeat (4) cyc();
        bus.req = 3'b000;
        cyc();
        bus.ac_ref = 1'b0;

        // Page fail and ack in the same MEM cycle: page fail wins.
        bus.req      = 3'b010;
        bus.req_src  = 6'b00_11_00;
        bus.req_vmax = 6'b00_00_00;
        push("pfack_load",  e_load(3'b010, 2'b11, 2'b00));
        push("pfack_check", e_grant(3'b010));
        push("pfack_mem0",  e_mem(3'b010, 1'b0));
        push("pfack_trap",  e_trap(3'b010, 3'b100));
        push("pfack_idle",  e_idle());
        repeat (3) cyc();
        bus.page_fail = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.req       = 3'b000;
        cyc();
        bus.page_fail = 1'b0;
        bus.mem_ack   = 1'b0;
        cyc();

        // No ack: NXM after four MEM cycles; req dropped mid-operation is ignored.
        bus.req       = 3'b001;
        bus.req_write = 3'b001;
        bus.req_src   = 6'b00_00_00;
        bus.req_vmax  = 6'b00_00_11;
        push("nxm_load",  e_load(3'b001, 2'b00, 2'b11));
        push("nxm_check", e_grant(3'b001));
        push("nxm_mem0",  e_mem(3'b001, 1'b1));
        push("nxm_mem1",  e_mem(3'b001, 1'b1));
        push("nxm_mem2",  e_mem(3'b001, 1'b1));
        push("nxm_mem3",  e_mem(3'b001, 1'b1));
        push("nxm_trap",  e_trap(3'b001, 3'b010));
        push("nxm_idle",  e_idle());
        cyc();
        bus.req = 3'b000;
        repeat (7) cyc();

        // Write with write-break armed and address match: break trap, no MBOX cycle.
        bus.req         = 3'b001;
        bus.match_13_35 = 1'b1;
        bus.brk_en_wr   = 1'b1;
        push("brk_load",  e_load(3'b001, 2'b00, 2'b11));
        push("brk_check", e_grant(3'b001));
        push("brk_trap",  e_trap(3'b001, 3'b001));
        push("brk_idle",  e_idle());
        repeat (2) cyc();
        bus.req = 3'b000;
        repeat (2) cyc();

        // Same write with only read-break armed: normal ref, ack on the timeout cycle wins.
        bus.req       = 3'b001;
        bus.brk_en_wr = 1'b0;
        bus.brk_en_rd = 1'b1;
        push("nbrk_load",  e_load(3'b001, 2'b00, 2'b11));
        push("nbrk_check", e_grant(3'b001));
        push("nbrk_mem0",  e_mem(3'b001, 1'b1));
        push("nbrk_mem1",  e_mem(3'b001, 1'b1));
        push("nbrk_mem2",  e_mem(3'b001, 1'b1));
        push("nbrk_mem3",  e_mem(3'b001, 1'b1));
        push("nbrk_done",  e_done(3'b001));
        push("nbrk_idle",  e_idle());
        repeat (6) cyc();
        bus.mem_ack = 1'b1;
        bus.req     = 3'b000;
        cyc();
        bus.mem_ack     = 1'b0;
        bus.match_13_35 = 1'b0;
        bus.brk_en_rd   = 1'b0;
        bus.req_write   = 3'b000;
        cyc();

        // Reset asserted during MEM clears outputs at once; held req is regranted after release.
        bus.req      = 3'b001;
        bus.req_src  = 6'b00_00_01;
        bus.req_vmax = 6'b00_00_10;
        push("rm_load",  e_load(3'b001, 2'b01, 2'b10));
        push("rm_check", e_grant(3'b001));
        push("rm_mem0",  e_mem(3'b001, 1'b0));
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        push("rm_reset", e_idle());
        pop_cmp();
        #1;
        rst_n = 1'b1;
        push("rm_reload", e_load(3'b001, 2'b01, 2'b10));
        push("rm_check2", e_grant(3'b001));
        push("rm_mem0b",  e_mem(3'b001, 1'b0));
        push("rm_mem1b",  e_mem(3'b001, 1'b0));
        push("rm_done",   e_done(3'b001));
        push("rm_idle",   e_idle());
        repeat (4) cyc();
        bus.mem_ack = 1'b1;
        bus.req     = 3'b000;
        cyc();
        bus.mem_ack = 1'b0;
        cyc();

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
